// File: rtl/vga_sched_pkg.sv
// Shared constants for the VGA draw scheduler: FSM encoding, slot indices, pixel field widths.
package vga_sched_pkg;
  localparam int NUM_SLOTS   = 2;
  localparam int X_W         = 8;
  localparam int Y_W         = 7;
  localparam int C_W         = 3;
  localparam int SLOT_PADDLE = 0;
  localparam int SLOT_BALL   = 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GO0   = 3'd1,
    BUSY0 = 3'd2,
    GO1   = 3'd3,
    BUSY1 = 3'd4
  } sched_state_e;
endpackage

// File: rtl/frame_tick_gen.sv
// Free-running frame counter; tick_o pulses for one cycle on the last count of every frame.
module frame_tick_gen #(
  parameter int FRAME_CYCLES = 833333
) (
  input  logic clk_i,
  input  logic resetn_i,
  output logic tick_o
);
  localparam int CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) cnt_q <= '0;
    else           cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == LAST);
endmodule

// File: rtl/vga_draw_scheduler.sv
// Frame-paced arbiter sharing the vga_adapter plot port between paddle (slot 0) and ball (slot 1).
// Optional watchdog on stuck drawers is built when VGA_DRAW_SCHED_TIMEOUT_EN is defined.
module vga_draw_scheduler
  import vga_sched_pkg::*;
#(
  parameter int FRAME_CYCLES   = 833333,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     enable,
  input  logic [NUM_SLOTS*X_W-1:0] x_in,
  input  logic [NUM_SLOTS*Y_W-1:0] y_in,
  input  logic [NUM_SLOTS*C_W-1:0] colour_in,
  input  logic [NUM_SLOTS-1:0]     plot_in,
  input  logic [NUM_SLOTS-1:0]     done_in,
  output logic [NUM_SLOTS-1:0]     go_out,
  output logic [NUM_SLOTS-1:0]     grant,
  output logic [X_W-1:0]           x_out,
  output logic [Y_W-1:0]           y_out,
  output logic [C_W-1:0]           colour_out,
  output logic                     plot_out,
  output logic                     frame_tick,
  output logic                     overrun,
  output logic                     timeout
);
  sched_state_e state_q, state_d;
  logic pending_q, pending_d;
  logic overrun_q, overrun_d;
  logic wd_expire;

  frame_tick_gen #(.FRAME_CYCLES(FRAME_CYCLES)) u_tick (
    .clk_i    (clk),
    .resetn_i (resetn),
    .tick_o   (frame_tick)
  );

`ifdef VGA_DRAW_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic timeout_q, timeout_d;

  // wd_q counts completed BUSY cycles of the current slot; expiry only if done is not arriving now
  always_comb begin
    wd_d      = '0;
    wd_expire = 1'b0;
    case (state_q)
      BUSY0: begin
        wd_d      = wd_q + WD_W'(1);
        wd_expire = (wd_q == WD_LAST) && !done_in[SLOT_PADDLE];
      end
      BUSY1: begin
        wd_d      = wd_q + WD_W'(1);
        wd_expire = (wd_q == WD_LAST) && !done_in[SLOT_BALL];
      end
      default: wd_d = '0;
    endcase
    timeout_d = timeout_q | wd_expire;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign wd_expire = 1'b0;
  assign timeout   = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    go_out    = '0;
    grant     = '0;
    // A tick that lands on an in-flight frame is remembered once, never stacked
    if (frame_tick && (state_q != IDLE)) begin
      overrun_d = 1'b1;
      pending_d = 1'b1;
    end
    case (state_q)
      IDLE: begin
        if ((frame_tick || pending_q) && enable) begin
          state_d   = GO0;
          pending_d = 1'b0;
        end
      end
      GO0: begin
        go_out[SLOT_PADDLE] = 1'b1;
        grant[SLOT_PADDLE]  = 1'b1;
        state_d             = BUSY0;
      end
      BUSY0: begin
        grant[SLOT_PADDLE] = 1'b1;
        if (done_in[SLOT_PADDLE] || wd_expire) state_d = GO1;
      end
      GO1: begin
        go_out[SLOT_BALL] = 1'b1;
        grant[SLOT_BALL]  = 1'b1;
        state_d           = BUSY1;
      end
      BUSY1: begin
        grant[SLOT_BALL] = 1'b1;
        if (done_in[SLOT_BALL] || wd_expire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign overrun = overrun_q;

  // Zero-latency mux; the adapter registers its inputs
  always_comb begin
    x_out      = '0;
    y_out      = '0;
    colour_out = '0;
    plot_out   = 1'b0;
    if (grant[SLOT_PADDLE]) begin
      x_out      = x_in[SLOT_PADDLE*X_W +: X_W];
      y_out      = y_in[SLOT_PADDLE*Y_W +: Y_W];
      colour_out = colour_in[SLOT_PADDLE*C_W +: C_W];
      plot_out   = plot_in[SLOT_PADDLE];
    end else if (grant[SLOT_BALL]) begin
      x_out      = x_in[SLOT_BALL*X_W +: X_W];
      y_out      = y_in[SLOT_BALL*Y_W +: Y_W];
      colour_out = colour_in[SLOT_BALL*C_W +: C_W];
      plot_out   = plot_in[SLOT_BALL];
    end
  end
endmodule

// File: tb/tb_vga_draw_scheduler.sv
// Directed bench for vga_draw_scheduler with stub drawers and a go-pulse scoreboard.
// Covers the watchdog path when VGA_DRAW_SCHED_TIMEOUT_EN is defined.
module tb_vga_draw_scheduler;
  localparam int FC = 100;
  localparam int TC = 50;

  logic        clk = 1'b0;
  logic        resetn;
  logic        enable;
  logic [15:0] x_in;
  logic [13:0] y_in;
  logic [5:0]  colour_in;
  logic [1:0]  plot_in;
  logic [1:0]  done_in;
  logic [1:0]  go_out;
  logic [1:0]  grant;
  logic [7:0]  x_out;
  logic [6:0]  y_out;
  logic [2:0]  colour_out;
  logic        plot_out;
  logic        frame_tick;
  logic        overrun;
  logic        timeout;

  always #5 clk = ~clk;

  vga_draw_scheduler #(.FRAME_CYCLES(FC), .TIMEOUT_CYCLES(TC)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .enable     (enable),
    .x_in       (x_in),
    .y_in       (y_in),
    .colour_in  (colour_in),
    .plot_in    (plot_in),
    .done_in    (done_in),
    .go_out     (go_out),
    .grant      (grant),
    .x_out      (x_out),
    .y_out      (y_out),
    .colour_out (colour_out),
    .plot_out   (plot_out),
    .frame_tick (frame_tick),
    .overrun    (overrun),
    .timeout    (timeout)
  );

  // Bench cycle number: 0 in the cycle where resetn is released
  int cyc = 0;
  always @(posedge clk) cyc <= (resetn === 1'b1) ? cyc + 1 : 0;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [1:0] go;
    int         at;
  } go_ev_t;
  go_ev_t exp_q[$];

  int dly[2] = '{16, 16};
  int tgt[2] = '{-1, -1};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Stub drawers: pulse done dly cycles after their go (dly 0 = never)
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (cyc == 0) tgt[i] = -1;
      else if (go_out[i] === 1'b1) tgt[i] = (dly[i] == 0) ? -1 : cyc + dly[i];
    end
    done_in[0] = (cyc == tgt[0]);
    done_in[1] = (cyc == tgt[1]);
  end

  // Scoreboard: every go pulse must match the next expected (slot, cycle)
  always @(negedge clk) begin
    go_ev_t ev;
    if (cyc > 0) begin
      chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
      if (go_out !== 2'b00) begin
        if (exp_q.size() == 0) begin
          chk("go_unexpected", 32'(go_out), 32'd0);
        end else begin
          ev = exp_q.pop_front();
          chk("go_slot", 32'(go_out), 32'(ev.go));
          chk("go_cycle", cyc, ev.at);
          chk("grant_with_go", 32'(grant), 32'(go_out));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    resetn    = 1'b0;
    enable    = 1'b1;
    x_in      = '0;
    y_in      = '0;
    colour_in = '0;
    plot_in   = '0;
    repeat (3) @(negedge clk);
    chk("rst_go", 32'(go_out), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_plot", 32'(plot_out), 32'd0);
    chk("rst_x", 32'(x_out), 32'd0);
    chk("rst_y", 32'(y_out), 32'd0);
    chk("rst_colour", 32'(colour_out), 32'd0);
    chk("rst_tick", 32'(frame_tick), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    resetn = 1'b1;

    // Nominal frame plus mux isolation
    exp_q.push_back('{2'b01, 100});
    exp_q.push_back('{2'b10, 117});
    wait_cyc(98);
    chk("tick_early", 32'(frame_tick), 32'd0);
    wait_cyc(99);
    chk("tick_first", 32'(frame_tick), 32'd1);
    x_in      = {8'd200, 8'd37};
    y_in      = {7'd99, 7'd12};
    colour_in = {3'd5, 3'd2};
    plot_in   = 2'b10;
    wait_cyc(105);
    chk("mux0_x", 32'(x_out), 32'd37);
    chk("mux0_y", 32'(y_out), 32'd12);
    chk("mux0_colour", 32'(colour_out), 32'd2);
    chk("mux0_plot_isolated", 32'(plot_out), 32'd0);
    chk("mux0_grant", 32'(grant), 32'd1);
    plot_in = 2'b11;
    wait_cyc(107);
    chk("mux0_plot", 32'(plot_out), 32'd1);
    chk("mux0_x_hold", 32'(x_out), 32'd37);
    wait_cyc(116);
    chk("handoff_pre", 32'(grant), 32'd1);
    wait_cyc(117);
    chk("handoff_post", 32'(grant), 32'd2);
    wait_cyc(120);
    chk("mux1_x", 32'(x_out), 32'd200);
    chk("mux1_y", 32'(y_out), 32'd99);
    chk("mux1_colour", 32'(colour_out), 32'd5);
    chk("mux1_plot", 32'(plot_out), 32'd1);
    wait_cyc(133);
    chk("busy1_last", 32'(grant), 32'd2);
    wait_cyc(134);
    chk("idle_grant", 32'(grant), 32'd0);
    chk("idle_x", 32'(x_out), 32'd0);
    chk("idle_plot", 32'(plot_out), 32'd0);
    chk("nominal_overrun", 32'(overrun), 32'd0);
    chk("nominal_timeout", 32'(timeout), 32'd0);

    // Overrun: slot 1 stalls across two ticks, one pending frame follows
    dly[1] = 250;
    exp_q.push_back('{2'b01, 200});
    exp_q.push_back('{2'b10, 217});
    wait_cyc(298);
    chk("overrun_before", 32'(overrun), 32'd0);
    wait_cyc(300);
    chk("overrun_set", 32'(overrun), 32'd1);
    dly[1] = 8;
    exp_q.push_back('{2'b01, 469});
    exp_q.push_back('{2'b10, 486});
    exp_q.push_back('{2'b01, 500});
    exp_q.push_back('{2'b10, 517});
    wait_cyc(467);
    chk("stall_grant", 32'(grant), 32'd2);
    wait_cyc(468);
    chk("stall_exit_idle", 32'(grant), 32'd0);
    wait_cyc(496);
    chk("no_stacked_frame", 32'(grant), 32'd0);
    chk("overrun_sticky", 32'(overrun), 32'd1);

    // Reset during BUSY0
    exp_q.push_back('{2'b01, 600});
    wait_cyc(605);
    chk("pre_reset_grant", 32'(grant), 32'd1);
    resetn = 1'b0;
    @(negedge clk);
    chk("midrst_grant", 32'(grant), 32'd0);
    chk("midrst_go", 32'(go_out), 32'd0);
    chk("midrst_plot", 32'(plot_out), 32'd0);
    chk("midrst_x", 32'(x_out), 32'd0);
    chk("midrst_overrun", 32'(overrun), 32'd0);
    chk("midrst_sb_empty", exp_q.size(), 0);
    resetn = 1'b1;
    dly[1] = 16;
    exp_q.push_back('{2'b01, 100});
    exp_q.push_back('{2'b10, 117});

    // Pause across tick 199; enable mid-frame drop does not abort
    wait_cyc(140);
    chk("post_rst_overrun", 32'(overrun), 32'd0);
    enable = 1'b0;
    wait_cyc(200);
    chk("pause_grant", 32'(grant), 32'd0);
    chk("pause_overrun", 32'(overrun), 32'd0);
    wait_cyc(250);
    enable = 1'b1;
    exp_q.push_back('{2'b01, 300});
    exp_q.push_back('{2'b10, 317});
    wait_cyc(305);
    chk("drop_en_busy0", 32'(grant), 32'd1);
    enable = 1'b0;
    wait_cyc(334);
    chk("drop_en_done", 32'(grant), 32'd0);
    wait_cyc(400);
    chk("pause2_grant", 32'(grant), 32'd0);
    chk("pause2_overrun", 32'(overrun), 32'd0);
    wait_cyc(410);
    enable = 1'b1;

    // Slot 0 never finishes
    dly[0] = 0;
    exp_q.push_back('{2'b01, 500});
`ifdef VGA_DRAW_SCHED_TIMEOUT_EN
    exp_q.push_back('{2'b10, 551});
    wait_cyc(550);
    chk("wd_busy0_last", 32'(grant), 32'd1);
    chk("wd_timeout_before", 32'(timeout), 32'd0);
    wait_cyc(551);
    chk("wd_grant_moved", 32'(grant), 32'd2);
    wait_cyc(552);
    chk("wd_timeout_set", 32'(timeout), 32'd1);
    wait_cyc(568);
    chk("wd_slot1_served", 32'(grant), 32'd0);
    wait_cyc(575);
`else
    wait_cyc(560);
    chk("stuck_grant", 32'(grant), 32'd1);
    wait_cyc(690);
    chk("stuck_grant_held", 32'(grant), 32'd1);
    chk("stuck_timeout", 32'(timeout), 32'd0);
`endif
    chk("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
